// File: rtl/mem_arbiter2_if.sv
// Request/ack bundle for both requesters plus the single-port RAM connection.
// The slave view belongs to the arbiter; the master view is the requester/RAM side.
interface mem_arbiter2_if #(
   parameter int AW = 14,
   parameter int DW = 16
);
   logic          a_req;
   logic          a_we;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_wdata;
   logic          a_ack;
   logic [DW-1:0] a_rdata;

   logic          b_req;
   logic          b_we;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_wdata;
   logic          b_ack;
   logic [DW-1:0] b_rdata;

   logic [AW-1:0] mem_address;
   logic          mem_load;
   logic [DW-1:0] mem_in;
   logic [DW-1:0] mem_out;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_out,
      output a_ack, a_rdata, b_ack, b_rdata, mem_address, mem_load, mem_in
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_out,
      input  a_ack, a_rdata, b_ack, b_rdata, mem_address, mem_load, mem_in
   );
endinterface

// File: rtl/mem_arbiter2.sv
// Round-robin share of one single-port RAM between ports A and B; ack two cycles after req.
// Requests wait (req held) while the other port is served; one access per cycle.
module mem_arbiter2 #(
   parameter int AW = 14,
   parameter int DW = 16
) (
   input  logic           clock,
   input  logic           reset,
   mem_arbiter2_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_A = 2'd1,
      SERVE_B = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          last_b_q, last_b_d;
   logic          a_ack_q, a_ack_d;
   logic          b_ack_q, b_ack_d;
   logic [DW-1:0] a_rdata_q, a_rdata_d;
   logic [DW-1:0] b_rdata_q, b_rdata_d;
   logic          elig_a, elig_b;
   logic [AW-1:0] mem_address;
   logic          mem_load;
   logic [DW-1:0] mem_in;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         last_b_q  <= 1'b1;
         a_ack_q   <= 1'b0;
         b_ack_q   <= 1'b0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         last_b_q  <= last_b_d;
         a_ack_q   <= a_ack_d;
         b_ack_q   <= b_ack_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
      end
   end

   // A port's req still shows its finished request during its own SERVE cycle.
   always_comb begin
      elig_a   = bus.a_req && (state_q != SERVE_A);
      elig_b   = bus.b_req && (state_q != SERVE_B);
      state_d  = IDLE;
      last_b_d = last_b_q;
      if (elig_a && elig_b) begin
         state_d = last_b_q ? SERVE_A : SERVE_B;
      end else if (elig_a) begin
         state_d = SERVE_A;
      end else if (elig_b) begin
         state_d = SERVE_B;
      end
      if (state_d == SERVE_A) begin
         last_b_d = 1'b0;
      end else if (state_d == SERVE_B) begin
         last_b_d = 1'b1;
      end

      a_ack_d   = (state_q == SERVE_A);
      b_ack_d   = (state_q == SERVE_B);
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      if ((state_q == SERVE_A) && !bus.a_we) begin
         a_rdata_d = bus.mem_out;
      end
      if ((state_q == SERVE_B) && !bus.b_we) begin
         b_rdata_d = bus.mem_out;
      end
   end

   always_comb begin
      mem_address = {AW{1'b0}};
      mem_in      = '0;
      mem_load    = 1'b0;
      case (state_q)
         SERVE_A: begin
            mem_address = bus.a_addr;
            mem_in      = bus.a_wdata;
            mem_load    = bus.a_we & ~reset;
         end
         SERVE_B: begin
            mem_address = bus.b_addr;
            mem_in      = bus.b_wdata;
            mem_load    = bus.b_we & ~reset;
         end
         default: begin
            mem_address = {AW{1'b0}};
            mem_in      = '0;
            mem_load    = 1'b0;
         end
      endcase
   end

   assign bus.mem_address = mem_address;
   assign bus.mem_in      = mem_in;
   assign bus.mem_load    = mem_load;
   assign bus.a_ack       = a_ack_q;
   assign bus.b_ack       = b_ack_q;
   assign bus.a_rdata     = a_rdata_q;
   assign bus.b_rdata     = b_rdata_q;

endmodule

// File: tb/tb_mem_arbiter2.sv
// Bench for mem_arbiter2: directed scenarios then random traffic against a port-level model.
module tb_mem_arbiter2;

   logic clk = 1'b0;
   logic rst;
   logic ram_init;
   always #5 clk = ~clk;

   mem_arbiter2_if #(.AW(14), .DW(16)) bus();
   mem_arbiter2 #(.AW(14), .DW(16)) dut (.clock(clk), .reset(rst), .bus(bus));

   // RAM16K-style memory: combinational read, write on posedge when load
   logic [15:0] ram [0:16383];
   assign bus.mem_out = ram[bus.mem_address];
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 16384; i++) ram[i] <= init_val(i);
      end else if (bus.mem_load) begin
         ram[bus.mem_address] <= bus.mem_in;
      end
   end

   function automatic logic [15:0] init_val(input int i);
      if (i == 1) return 16'h0011;
      if (i == 2) return 16'h0022;
      return 16'(i);
   endfunction

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Port-level model: which port is being served now, who was served last, shadow memory.
   logic [15:0] ref_mem [0:16383];
   int          m_cur;      // 0 none, 1 A, 2 B
   bit          m_last_a;
   bit          m_a_ack, m_b_ack;
   logic [15:0] m_a_rdata, m_b_rdata;

   task automatic model_reset();
      m_cur = 0; m_last_a = 1'b0; m_a_ack = 1'b0; m_b_ack = 1'b0;
      m_a_rdata = 16'h0; m_b_rdata = 16'h0;
   endtask

   task automatic model_edge();
      bit want_a, want_b;
      int nxt;
      if (rst) begin
         model_reset();
         return;
      end
      m_a_ack = (m_cur == 1);
      m_b_ack = (m_cur == 2);
      if (m_cur == 1) begin
         if (bus.a_we) ref_mem[bus.a_addr] = bus.a_wdata;
         else          m_a_rdata = ref_mem[bus.a_addr];
      end else if (m_cur == 2) begin
         if (bus.b_we) ref_mem[bus.b_addr] = bus.b_wdata;
         else          m_b_rdata = ref_mem[bus.b_addr];
      end
      want_a = bus.a_req && (m_cur != 1);
      want_b = bus.b_req && (m_cur != 2);
      if (want_a && want_b) nxt = m_last_a ? 2 : 1;
      else if (want_a)      nxt = 1;
      else if (want_b)      nxt = 2;
      else                  nxt = 0;
      if (nxt == 1) m_last_a = 1'b1;
      if (nxt == 2) m_last_a = 1'b0;
      m_cur = nxt;
   endtask

   task automatic check_comb();
      logic [13:0] e_addr;
      logic [15:0] e_in;
      logic        e_ld;
      e_addr = 14'h0; e_in = 16'h0; e_ld = 1'b0;
      if (m_cur == 1) begin
         e_addr = bus.a_addr; e_in = bus.a_wdata; e_ld = bus.a_we & ~rst;
      end else if (m_cur == 2) begin
         e_addr = bus.b_addr; e_in = bus.b_wdata; e_ld = bus.b_we & ~rst;
      end
      chk("mem_address", 32'(bus.mem_address), 32'(e_addr));
      chk("mem_in", 32'(bus.mem_in), 32'(e_in));
      chk("mem_load", 32'(bus.mem_load), 32'(e_ld));
   endtask

   task automatic check_regs();
      chk("a_ack", 32'(bus.a_ack), 32'(m_a_ack));
      chk("b_ack", 32'(bus.b_ack), 32'(m_b_ack));
      chk("a_rdata", 32'(bus.a_rdata), 32'(m_a_rdata));
      chk("b_rdata", 32'(bus.b_rdata), 32'(m_b_rdata));
   endtask

   // Inputs are set at the negedge; one step covers the following posedge.
   task automatic step();
      #1;
      check_comb();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check_regs();
   endtask

   task automatic set_a(input bit req, input bit we, input logic [13:0] addr, input logic [15:0] wd);
      bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
   endtask

   task automatic set_b(input bit req, input bit we, input logic [13:0] addr, input logic [15:0] wd);
      bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      ram_init = 1'b1;
      set_a(0, 0, 14'h0, 16'h0);
      set_b(0, 0, 14'h0, 16'h0);
      for (int i = 0; i < 16384; i++) ref_mem[i] = init_val(i);
      @(posedge clk);
      @(negedge clk);
      ram_init = 1'b0;
      model_reset();
      check_regs();
      step();
      rst = 1'b0;

      // write 0x1234 to addr 5
      set_a(1, 1, 14'd5, 16'h1234);
      step();
      chk("t1_load", 32'(bus.mem_load), 32'd1);
      chk("t1_addr", 32'(bus.mem_address), 32'd5);
      chk("t1_in", 32'(bus.mem_in), 32'h1234);
      step();
      chk("t1_a_ack", 32'(bus.a_ack), 32'd1);
      chk("t1_b_ack", 32'(bus.b_ack), 32'd0);
      set_a(0, 0, 14'h0, 16'h0);
      step();

      // read back, then a write that must not disturb a_rdata
      set_a(1, 0, 14'd5, 16'h0);
      step();
      step();
      chk("t2_a_ack", 32'(bus.a_ack), 32'd1);
      chk("t2_rdata", 32'(bus.a_rdata), 32'h1234);
      set_a(1, 1, 14'd3, 16'h5555);
      step();
      step();
      chk("t2_wr_ack", 32'(bus.a_ack), 32'd1);
      chk("t2_hold", 32'(bus.a_rdata), 32'h1234);
      set_a(0, 0, 14'h0, 16'h0);
      step();

      // B alone, back-to-back reads
      set_b(1, 0, 14'd2, 16'h0);
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("t4_load", 32'(bus.mem_load), 32'd0);
         chk("t4_b_ack", 32'(bus.b_ack), 32'(k % 2 == 0));
      end
      set_b(0, 0, 14'h0, 16'h0);
      step();
      chk("t4_rdata", 32'(bus.b_rdata), 32'h0022);

      // both continuously: A,B,A,B (B was served last)
      set_a(1, 0, 14'd1, 16'h0);
      set_b(1, 0, 14'd2, 16'h0);
      for (int k = 1; k <= 8; k++) begin
         step();
         if (k >= 2) begin
            chk("t3_alt", 32'(bus.a_ack ^ bus.b_ack), 32'd1);
            chk("t3_a_ack", 32'(bus.a_ack), 32'(k % 2 == 0));
         end
      end
      set_a(0, 0, 14'h0, 16'h0);
      step();
      chk("t3_last_b_ack", 32'(bus.b_ack), 32'd1);
      set_b(0, 0, 14'h0, 16'h0);
      step();
      chk("t3_a_rdata", 32'(bus.a_rdata), 32'h0011);
      chk("t3_b_rdata", 32'(bus.b_rdata), 32'h0022);

      // write then read of the same address on consecutive cycles
      set_a(1, 1, 14'd9, 16'hBEEF);
      step();
      set_b(1, 0, 14'd9, 16'h0);
      step();
      chk("t5_b_addr", 32'(bus.mem_address), 32'd9);
      set_a(0, 0, 14'h0, 16'h0);
      step();
      chk("t5_b_ack", 32'(bus.b_ack), 32'd1);
      chk("t5_b_rdata", 32'(bus.b_rdata), 32'hBEEF);
      set_b(0, 0, 14'h0, 16'h0);
      step();

      // reset during a write's SERVE cycle
      set_a(1, 1, 14'd7, 16'hDEAD);
      step();
      rst = 1'b1;
      set_a(0, 1, 14'd7, 16'hDEAD);
      #1;
      chk("t6_load_sup", 32'(bus.mem_load), 32'd0);
      step();
      chk("t6_no_ack", 32'(bus.a_ack), 32'd0);
      chk("t6_a_clr", 32'(bus.a_rdata), 32'd0);
      chk("t6_b_clr", 32'(bus.b_rdata), 32'd0);
      rst = 1'b0;
      set_a(1, 0, 14'd7, 16'h0);
      set_b(1, 0, 14'd2, 16'h0);
      step();
      chk("t6_tie_a", 32'(bus.mem_address), 32'd7);
      step();
      chk("t6_a_ack", 32'(bus.a_ack), 32'd1);
      chk("t6_a_rdata", 32'(bus.a_rdata), 32'h0007);
      set_a(0, 0, 14'h0, 16'h0);
      step();
      set_b(0, 0, 14'h0, 16'h0);
      step();

      // random traffic on a small address window, occasional reset
      for (int c = 0; c < 3000; c++) begin
         if (!bus.a_req || bus.a_ack) begin
            if ($urandom_range(0, 9) < 6)
               set_a(1, 1'($urandom_range(0, 1)), 14'($urandom_range(0, 15)), 16'($urandom));
            else
               set_a(0, 0, 14'h0, 16'h0);
         end
         if (!bus.b_req || bus.b_ack) begin
            if ($urandom_range(0, 9) < 6)
               set_b(1, 1'($urandom_range(0, 1)), 14'($urandom_range(0, 15)), 16'($urandom));
            else
               set_b(0, 0, 14'h0, 16'h0);
         end
         rst = ($urandom_range(0, 63) == 0);
         step();
      end
      rst = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
